// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one aligned byte/half/word access at a time over a
// valid/ready data bus, big-endian lanes, zero/sign-extended load results.
module lsu_ctrl #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_bmul,
  input  logic          req_sext,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_be,
  input  logic          bus_rvalid,
  input  logic [31:0]   bus_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    bmul_q, bmul_d;
  logic [1:0]    off_q, off_d;
  logic          sext_q, sext_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic [31:0]   bwdata_q, bwdata_d;
  logic [3:0]    bbe_q, bbe_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          req_err;
  logic [3:0]    req_be;
  logic [31:0]   req_wrep;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // Incoming request: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    req_err  = 1'b0;
    req_be   = 4'b0000;
    req_wrep = req_wdata;
    case (req_bmul)
      2'b00: begin
        req_be   = 4'b1000 >> req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_err  = req_addr[0];
        req_be   = req_addr[1] ? 4'b0011 : 4'b1100;
        req_wrep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_err  = |req_addr[1:0];
        req_be   = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
  end

  // Offset 0 is the most significant lane of the returned word.
  always_comb begin
    byte_sel = bus_rdata[31:24];
    case (off_q)
      2'd0:    byte_sel = bus_rdata[31:24];
      2'd1:    byte_sel = bus_rdata[23:16];
      2'd2:    byte_sel = bus_rdata[15:8];
      default: byte_sel = bus_rdata[7:0];
    endcase
    half_sel = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (bmul_q)
      2'b00:   load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    bmul_d   = bmul_q;
    off_d    = off_q;
    sext_d   = sext_q;
    baddr_d  = baddr_q;
    bwdata_d = bwdata_q;
    bbe_d    = bbe_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          bmul_d = req_bmul;
          off_d  = req_addr[1:0];
          sext_d = req_sext;
          if (req_err) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            baddr_d  = {req_addr[AW-1:2], 2'b00};
            bwdata_d = req_wrep;
            bbe_d    = req_be;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus_ready) begin
          if (we_q) begin
            rdata_d = 32'h0;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          rdata_d = load_ext;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      bmul_q   <= 2'b00;
      off_q    <= 2'b00;
      sext_q   <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= 32'h0;
      bbe_q    <= 4'b0000;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      bmul_q   <= bmul_d;
      off_q    <= off_d;
      sext_q   <= sext_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
      bbe_q    <= bbe_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign bus_valid  = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign bus_we     = we_q;
  assign bus_addr   = baddr_q;
  assign bus_wdata  = bwdata_q;
  assign bus_be     = bbe_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: drives requests and bus responses cycle by cycle
// and compares outputs against hand-computed values.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_bmul = 2'b00;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int compared = 0;
  int mismatched = 0;

  lsu_ctrl #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bmul(req_bmul), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; it is accepted at the next edge.
  task automatic applyStimulus(input logic we, input logic [1:0] bmul, input logic sext,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_bmul  = bmul;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #12;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
    checkOutput("rst_bus_we", {31'b0, bus_we}, 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_be", {28'b0, bus_be}, 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Load byte, offset 3, sign-extended
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    checkOutput("lb_bus_valid", {31'b0, bus_valid}, 32'd1);
    checkOutput("lb_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("lb_bus_addr", bus_addr, 32'h100);
    checkOutput("lb_bus_be", {28'b0, bus_be}, 32'h1);
    checkOutput("lb_bus_we", {31'b0, bus_we}, 32'd0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    checkOutput("lb_wait_bus_valid", {31'b0, bus_valid}, 32'd0);
    checkOutput("lb_wait_resp_valid", {31'b0, resp_valid}, 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h112233F4;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("lb_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("lb_resp_rdata", resp_rdata, 32'hFFFFFFF4);
    checkOutput("lb_resp_err", {31'b0, resp_err}, 32'd0);
    tick();
    checkOutput("lb_resp_pulse_end", {31'b0, resp_valid}, 32'd0);
    checkOutput("lb_req_ready_back", {31'b0, req_ready}, 32'd1);
    checkOutput("lb_rdata_held", resp_rdata, 32'hFFFFFFF4);

    // Load half, offset 2, zero-extended (accepted the cycle after RESP)
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
    checkOutput("lh_bus_be", {28'b0, bus_be}, 32'h3);
    checkOutput("lh_bus_addr", bus_addr, 32'h200);
    bus_ready = 1'b1;
    tick();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hAAAA8001;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("lh_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("lh_resp_rdata", resp_rdata, 32'h00008001);
    tick();

    // Store byte, offset 1, with a three-cycle bus stall
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sb_stall_bus_valid", {31'b0, bus_valid}, 32'd1);
      checkOutput("sb_stall_bus_wdata", bus_wdata, 32'hA5A5A5A5);
      checkOutput("sb_stall_bus_be", {28'b0, bus_be}, 32'h4);
      checkOutput("sb_stall_bus_we", {31'b0, bus_we}, 32'd1);
      checkOutput("sb_stall_bus_addr", bus_addr, 32'h300);
      tick();
    end
    bus_ready = 1'b1;
    checkOutput("sb_hs_bus_valid", {31'b0, bus_valid}, 32'd1);
    tick();
    bus_ready = 1'b0;
    checkOutput("sb_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("sb_resp_rdata", resp_rdata, 32'h0);
    checkOutput("sb_resp_err", {31'b0, resp_err}, 32'd0);
    checkOutput("sb_bus_valid_off", {31'b0, bus_valid}, 32'd0);
    tick();

    // Misaligned word, then reserved size
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h402, 32'h0);
    checkOutput("mw_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("mw_resp_err", {31'b0, resp_err}, 32'd1);
    checkOutput("mw_resp_rdata", resp_rdata, 32'h0);
    checkOutput("mw_bus_valid", {31'b0, bus_valid}, 32'd0);
    tick();
    checkOutput("mw_idle_bus_valid", {31'b0, bus_valid}, 32'd0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    checkOutput("rsv_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("rsv_resp_err", {31'b0, resp_err}, 32'd1);
    checkOutput("rsv_bus_valid", {31'b0, bus_valid}, 32'd0);
    tick();
    checkOutput("rsv_err_held", {31'b0, resp_err}, 32'd1);

    // Load word; rvalid during ISSUE must be ignored
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h12345678;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("lw_still_issue", {31'b0, bus_valid}, 32'd1);
    checkOutput("lw_no_early_resp", {31'b0, resp_valid}, 32'd0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    checkOutput("lw_wait_resp_valid", {31'b0, resp_valid}, 32'd0);
    tick();
    checkOutput("lw_wait_hold", {31'b0, resp_valid}, 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEADBEEF;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("lw_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("lw_resp_rdata", resp_rdata, 32'hDEADBEEF);
    checkOutput("lw_resp_err", {31'b0, resp_err}, 32'd0);
    tick();

    // Asynchronous reset while waiting for read data
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("ar_bus_addr", bus_addr, 32'h0);
    checkOutput("ar_bus_be", {28'b0, bus_be}, 32'h0);
    checkOutput("ar_resp_rdata", resp_rdata, 32'h0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h55555555;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("ar_no_resp", {31'b0, resp_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    checkOutput("ar_no_resp_after", {31'b0, resp_valid}, 32'd0);
    tick();

    // Fresh load after reset: half at offset 0, sign-extended
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h604, 32'h0);
    checkOutput("pr_bus_be", {28'b0, bus_be}, 32'hC);
    checkOutput("pr_bus_addr", bus_addr, 32'h604);
    bus_ready = 1'b1;
    tick();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h8001ABCD;
    tick();
    bus_rvalid = 1'b0;
    checkOutput("pr_resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("pr_resp_rdata", resp_rdata, 32'hFFFF8001);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
